// File: rtl/demux_pkg.sv
// Shared types and sizing for the 1-to-7 demux/collector.
// Slot count and select width live here so the interface, counter and top agree.
package demux_pkg;

   localparam int N_SLOTS   = 7;
   localparam int SEL_W     = 3;
   localparam int LAST_SLOT = N_SLOTS - 1;

   typedef enum logic {
      ADDR = 1'b0,
      AUTO = 1'b1
   } state_t;

endpackage

// File: rtl/demux1to7_collector_if.sv
// Handshake/data bundle between a bit source and the demux/collector.
// SelErr exists only when DEMUX_SEL_ERR_EN is defined.
interface demux1to7_collector_if;
   import demux_pkg::*;

   logic               DataIn;
   logic               Valid;
   logic               AutoMode;
   logic [SEL_W-1:0]   Select;
   logic               Clear;
   logic [N_SLOTS-1:0] Out;
   logic [SEL_W-1:0]   Ptr;
   logic               FrameDone;
`ifdef DEMUX_SEL_ERR_EN
   logic               SelErr;
`endif

   modport master (
      output DataIn, Valid, AutoMode, Select, Clear,
`ifdef DEMUX_SEL_ERR_EN
      input  SelErr,
`endif
      input  Out, Ptr, FrameDone
   );

   modport slave (
      input  DataIn, Valid, AutoMode, Select, Clear,
`ifdef DEMUX_SEL_ERR_EN
      output SelErr,
`endif
      output Out, Ptr, FrameDone
   );

endinterface

// File: rtl/demux_ptr_counter.sv
// Auto-mode slot pointer: increments per collected bit, wraps after the last slot.
// Clear has priority over increment.
module demux_ptr_counter
   import demux_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [SEL_W-1:0] ptr_o,
   output logic             at_last_o
);

   logic [SEL_W-1:0] ptr_q;
   logic [SEL_W-1:0] ptr_d;

   assign at_last_o = (ptr_q == SEL_W'(LAST_SLOT));
   assign ptr_o     = ptr_q;

   always_comb begin
      ptr_d = ptr_q;
      if (clr_i) begin
         ptr_d = '0;
      end else if (inc_i) begin
         ptr_d = at_last_o ? '0 : ptr_q + SEL_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/demux1to7_collector.sv
// Registered 1-to-7 demux: addressed writes into Out, or serial collection of 7-bit frames.
// Optional SelErr pulse on out-of-range addressed writes when DEMUX_SEL_ERR_EN is defined.
//
// state | meaning
// ADDR  | Valid writes DataIn into Out[Select]; Ptr held at 0
// AUTO  | Valid shifts DataIn into shadow[Ptr]; Out updated only on frame completion
module demux1to7_collector
   import demux_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   demux1to7_collector_if.slave  bus
);

   localparam logic [N_SLOTS-1:0] LAST_MASK = N_SLOTS'(1) << LAST_SLOT;

   state_t             state_q, state_d;
   logic [N_SLOTS-1:0] out_q, out_d;
   logic [N_SLOTS-1:0] shadow_q, shadow_d;
   logic               frame_done_q, frame_done_d;
   logic               sel_err_q, sel_err_d;

   logic               mode_chg;
   logic               ptr_inc;
   logic               ptr_clr;
   logic [SEL_W-1:0]   ptr;
   logic               at_last;
   logic [N_SLOTS-1:0] sel_mask;
   logic [N_SLOTS-1:0] ptr_mask;

   demux_ptr_counter u_ptr (
      .clock     (clock),
      .reset     (reset),
      .inc_i     (ptr_inc),
      .clr_i     (ptr_clr),
      .ptr_o     (ptr),
      .at_last_o (at_last)
   );

   assign sel_mask = N_SLOTS'(1) << bus.Select;
   assign ptr_mask = N_SLOTS'(1) << ptr;

   always_comb begin
      state_d      = bus.AutoMode ? AUTO : ADDR;
      mode_chg     = (state_d != state_q);
      out_d        = out_q;
      shadow_d     = shadow_q;
      frame_done_d = 1'b0;
      sel_err_d    = 1'b0;
      ptr_inc      = 1'b0;
      ptr_clr      = 1'b0;

      if (bus.Clear) begin
         out_d    = '0;
         shadow_d = '0;
         ptr_clr  = 1'b1;
      end else if (mode_chg) begin
         // Out deliberately holds across a mode switch; only the partial frame is dropped.
         shadow_d = '0;
         ptr_clr  = 1'b1;
      end else if (bus.Valid) begin
         unique case (state_q)
            ADDR: begin
               if (bus.Select < SEL_W'(N_SLOTS)) begin
                  out_d = bus.DataIn ? (out_q | sel_mask) : (out_q & ~sel_mask);
               end else begin
                  sel_err_d = 1'b1;
               end
            end
            AUTO: begin
               ptr_inc = 1'b1;
               if (at_last) begin
                  out_d        = (shadow_q & ~LAST_MASK) | ({N_SLOTS{bus.DataIn}} & LAST_MASK);
                  shadow_d     = '0;
                  frame_done_d = 1'b1;
               end else begin
                  shadow_d = bus.DataIn ? (shadow_q | ptr_mask) : (shadow_q & ~ptr_mask);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ADDR;
         out_q        <= '0;
         shadow_q     <= '0;
         frame_done_q <= 1'b0;
         sel_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         out_q        <= out_d;
         shadow_q     <= shadow_d;
         frame_done_q <= frame_done_d;
         sel_err_q    <= sel_err_d;
      end
   end

   assign bus.Out       = out_q;
   assign bus.Ptr       = ptr;
   assign bus.FrameDone = frame_done_q;
`ifdef DEMUX_SEL_ERR_EN
   assign bus.SelErr    = sel_err_q;
`else
   logic unused_sel_err;
   assign unused_sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_demux1to7_collector.sv
// Bench for demux1to7_collector: queue-based behavioural model checked every cycle,
// plus hand-computed literal checks. Honours DEMUX_SEL_ERR_EN.
module tb_demux1to7_collector;

   logic clock;
   logic reset;
   int   n_vec;
   int   n_err;
   bit   running;

   demux1to7_collector_if bus ();

   demux1to7_collector dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural model: Out as a bit array, the partial frame as a queue of bits.
   bit       m_out [7];
   bit       m_q [$];
   bit       m_auto;
   bit       m_fd;
   bit       m_selerr;

   function automatic logic [6:0] m_out_vec();
      logic [6:0] v;
      for (int k = 0; k < 7; k++) v[k] = m_out[k];
      return v;
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 7; k++) m_out[k] = 1'b0;
         m_q.delete();
         m_auto   = 1'b0;
         m_fd     = 1'b0;
         m_selerr = 1'b0;
      end else begin
         m_fd     = 1'b0;
         m_selerr = 1'b0;
         if (bus.Clear) begin
            for (int k = 0; k < 7; k++) m_out[k] = 1'b0;
            m_q.delete();
            m_auto = bus.AutoMode;
         end else if (bus.AutoMode != m_auto) begin
            m_q.delete();
            m_auto = bus.AutoMode;
         end else if (bus.Valid) begin
            if (!m_auto) begin
               if (int'(bus.Select) < 7) m_out[bus.Select] = bus.DataIn;
               else m_selerr = 1'b1;
            end else begin
               m_q.push_back(bus.DataIn);
               if (m_q.size() == 7) begin
                  for (int k = 0; k < 7; k++) m_out[k] = m_q[k];
                  m_q.delete();
                  m_fd = 1'b1;
               end
            end
         end
      end
   end

   always @(negedge clock) begin
      if (running) begin
         n_vec++;
         if (bus.Out !== m_out_vec() || bus.Ptr !== 3'(m_q.size()) || bus.FrameDone !== m_fd) begin
            n_err++;
            $display("FAIL cycle_cmp t=%0t Out=%b want %b Ptr=%0d want %0d FrameDone=%b want %b",
                     $time, bus.Out, m_out_vec(), bus.Ptr, m_q.size(), bus.FrameDone, m_fd);
         end
`ifdef DEMUX_SEL_ERR_EN
         n_vec++;
         if (bus.SelErr !== m_selerr) begin
            n_err++;
            $display("FAIL selerr_cmp t=%0t SelErr=%b want %b", $time, bus.SelErr, m_selerr);
         end
`endif
      end
   end

   task automatic check_lit(input string name, input logic [6:0] got, input logic [6:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%b want=%b", name, got, exp);
      end
   endtask

   // Drive one sample; returns just after the edge that consumed it.
   task automatic cyc(input logic v, input logic d, input logic am,
                      input logic [2:0] sel, input logic clr);
      @(negedge clock);
      #1;
      bus.Valid    = v;
      bus.DataIn   = d;
      bus.AutoMode = am;
      bus.Select   = sel;
      bus.Clear    = clr;
      @(posedge clock);
      #2;
   endtask

   initial begin
      logic [6:0] bits_a;
      logic [6:0] bits_b;
      int         fd_idx [$];

      n_vec = 0;
      n_err = 0;
      running = 1'b0;
      reset = 1'b1;
      bus.Valid = 1'b0; bus.DataIn = 1'b0; bus.AutoMode = 1'b0;
      bus.Select = 3'd0; bus.Clear = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      running = 1'b1;
      check_lit("reset_out", bus.Out, 7'b0000000);
      check_lit("reset_ptr", 7'(bus.Ptr), 7'd0);

      // Addressed writes
      cyc(1, 1, 0, 3'd3, 0);
      cyc(1, 1, 0, 3'd6, 0);
      cyc(1, 1, 0, 3'd0, 0);
      check_lit("addr_write3", bus.Out, 7'b1001001);
      cyc(1, 0, 0, 3'd3, 0);
      check_lit("addr_clear_bit3", bus.Out, 7'b1000001);

      // Out-of-range select
      cyc(1, 1, 0, 3'd7, 0);
      check_lit("sel7_hold", bus.Out, 7'b1000001);
`ifdef DEMUX_SEL_ERR_EN
      check_lit("selerr_pulse", 7'(bus.SelErr), 7'd1);
`endif
      cyc(0, 0, 0, 3'd0, 0);
`ifdef DEMUX_SEL_ERR_EN
      check_lit("selerr_drop", 7'(bus.SelErr), 7'd0);
`endif

      // Asynchronous reset mid-cycle
      @(negedge clock);
      #2;
      reset = 1'b1;
      #1;
      check_lit("async_rst_out", bus.Out, 7'b0000000);
      check_lit("async_rst_ptr", 7'(bus.Ptr), 7'd0);
      check_lit("async_rst_fd", 7'(bus.FrameDone), 7'd0);
      @(negedge clock);
      #1;
      reset = 1'b0;

      // Seed Out, then switch to AUTO and collect a frame with a gap
      cyc(1, 1, 0, 3'd2, 0);
      check_lit("seed_out", bus.Out, 7'b0000100);
      cyc(0, 0, 1, 3'd0, 0);
      bits_a = 7'b1001101;
      for (int i = 0; i < 6; i++) begin
         cyc(1, bits_a[i], 1, 3'd0, 0);
         if (i == 2) begin
            cyc(0, 0, 1, 3'd0, 0);
            cyc(0, 0, 1, 3'd0, 0);
         end
      end
      check_lit("auto_partial_hidden", bus.Out, 7'b0000100);
      check_lit("auto_ptr6", 7'(bus.Ptr), 7'd6);
      cyc(1, bits_a[6], 1, 3'd0, 0);
      check_lit("auto_frame", bus.Out, 7'b1001101);
      check_lit("auto_fd", 7'(bus.FrameDone), 7'd1);
      check_lit("auto_ptr_wrap", 7'(bus.Ptr), 7'd0);
      cyc(0, 0, 1, 3'd0, 0);
      check_lit("auto_fd_single", 7'(bus.FrameDone), 7'd0);

      // Clear in the middle of a frame, with a concurrent Valid
      for (int i = 0; i < 4; i++) cyc(1, 1, 1, 3'd0, 0);
      check_lit("clr_pre_ptr", 7'(bus.Ptr), 7'd4);
      cyc(1, 1, 1, 3'd0, 1);
      check_lit("clr_out", bus.Out, 7'b0000000);
      check_lit("clr_ptr", 7'(bus.Ptr), 7'd0);
      check_lit("clr_fd", 7'(bus.FrameDone), 7'd0);
      bits_b = 7'b1101010;
      for (int i = 0; i < 7; i++) cyc(1, bits_b[i], 1, 3'd0, 0);
      check_lit("fresh_frame", bus.Out, 7'b1101010);

      // Back-to-back frames: 14 consecutive valid bits, alternating 0/1
      for (int i = 0; i < 14; i++) begin
         cyc(1, 1'(i % 2), 1, 3'd0, 0);
         if (bus.FrameDone) fd_idx.push_back(i);
      end
      check_lit("b2b_count", 7'(fd_idx.size()), 7'd2);
      if (fd_idx.size() == 2) check_lit("b2b_spacing", 7'(fd_idx[1] - fd_idx[0]), 7'd7);
      check_lit("b2b_out", bus.Out, 7'b1010101);

      // Mode switch mid-frame discards the write and the partial frame
      for (int i = 0; i < 5; i++) cyc(1, 1, 1, 3'd0, 0);
      check_lit("sw_pre_ptr", 7'(bus.Ptr), 7'd5);
      cyc(1, 1, 0, 3'd1, 0);
      check_lit("sw_out_hold", bus.Out, 7'b1010101);
      check_lit("sw_ptr", 7'(bus.Ptr), 7'd0);
      cyc(1, 1, 0, 3'd1, 0);
      check_lit("sw_next_write", bus.Out, 7'b1010111);
      cyc(0, 0, 0, 3'd0, 0);

      running = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
